ahb_lite_fifo_slave: RTL and testbench
======================================

# ahb_lite_fifo_slave

AHB-Lite responder exposing a word-wide FIFO mailbox with status, control and interrupt registers. It connects to one decoder HSEL line and one slave-multiplexor input on the same bus as the memory and timer slaves. It adds programmable wait states and the two-cycle AHB ERROR response, which the existing slaves do not exercise.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- WAIT_STATES, 1: HREADY-low cycles inserted in every OKAY data phase, 0..3.
- HCLK  in  1  bus clock; all logic on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  30  word address (byte address bits [31:2]); bits [3:2] select the register.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size; only 3'b010 (word) is legal.
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data; valid when HREADY=1 in a read data phase, otherwise 0.
- HREADY  out  1  transfer-done / ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- Interrupt  out  1  level interrupt.

## Operation
- Register offsets (HADDR[3:2]):
  - 0 DATA: a write pushes; a read pops and returns the head.
  - 1 STATUS: read-only. bit0 = empty, bit1 = full, bits[15:8] = count, other bits 0.
  - 2 CTRL: read/write. bit0 = irq_en. bit1 = flush: write-1, self-clearing, always reads 0.
  - 3: reserved.
- An address phase is accepted when HSEL=1, HTRANS[1]=1 and HREADY=1.
  - Captured fields: offset, HWRITE, and the legality decision.
  - IDLE/BUSY transfers, or HSEL=0, produce a zero-wait OKAY with no side effects.
- A transfer is illegal, and gets an ERROR response, when any of these holds:
  - HSIZE is not 3'b010.
  - Offset is 3.
  - It is a write to STATUS.
  - It is a DATA write while the FIFO is full, or a DATA read while the FIFO is empty.
- Full and empty are evaluated on the count *after* any transfer completing on the same edge, so a back-to-back push then pop on a 1-entry FIFO is legal.
- Illegal transfers have no side effect: no push, no pop, no CTRL update.
- FSM states:
  - IDLE: no data phase pending; HREADY=1.
  - WAIT: legal transfer; HREADY=0 while the wait counter counts WAIT_STATES down to 0, then the completion cycle drives HREADY=1. With WAIT_STATES=0, go straight to completion.
  - ERR1: HRESP=1, HREADY=0.
  - ERR2: HRESP=1, HREADY=1.
- Side effects of a legal completion occur at the completion edge: push HWDATA, pop the head, or update CTRL.
- Flush zeroes the pointers and count at its completion edge.
- Interrupt = irq_en & !empty, registered; it updates one cycle after the count or CTRL changes.
- A new address phase may be accepted in the completion cycle (pipelined back-to-back transfers).
- Count is held as $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.

## Timing
- Reset values: HREADY=1, HRESP=0, HRDATA=0, Interrupt=0, FIFO empty, CTRL=0, FSM IDLE.
- OKAY data phase lasts WAIT_STATES+1 cycles. ERROR data phase always lasts exactly 2 cycles.
- HRDATA is driven only during a read completion cycle (HREADY=1). STATUS and CTRL reads reflect the value before the same-edge update.
- HRESETn low mid-transfer: the next cycle is IDLE with reset values; the pending push or pop is discarded.
- Full/empty boundaries: with DEPTH pushes, full=1 and a further push returns ERROR with count unchanged. A pop from empty returns ERROR with HRDATA=0.

## Structure
- Package ahb_lite_pkg holds:
  - HTRANS codes, HSIZE_WORD, and HRESP OKAY/ERROR.
  - Register offsets and the STATUS/CTRL bit positions.
  - The FSM state enum.
- Sub-module ahb_fifo_core: synchronous FIFO (push, pop, flush, data out, count, full, empty), reset by HRESETn. The bus FSM, legality check and registers stay in the top module.

## Test plan
- Reset, then an idle bus: HREADY=1, HRESP=0, Interrupt=0, STATUS reads 0x0000_0001.
- WAIT_STATES=1: write 0xA5A5_0001 to DATA, then read DATA. Each data phase holds HREADY low for 1 cycle; the read returns 0xA5A5_0001; STATUS returns to 0x1.
- DEPTH=8: push 8 words, then push a 9th. STATUS reads 0x0802. The 9th push gets ERR1 then ERR2, and a subsequent pop returns the first word.
- Pop while empty, an HSIZE=3'b000 access, and a write to offset 3: each gives a 2-cycle ERROR with no state change.
- Write CTRL=0x1 and push one word: Interrupt rises 1 cycle after the push completes. Write CTRL=0x3 (flush): STATUS=0x1 and Interrupt falls.
- Assert HRESETn low during the WAIT of a push: the word is not stored, HREADY=1 on the next cycle, and STATUS=0x1.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared constants, register map and bus FSM types for the AHB-Lite FIFO mailbox.
package ahb_lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 8;
  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_FLUSH   = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} bus_state_t;

  // Address-phase fields held across the data phase.
  typedef struct packed {
    logic [1:0] off;
    logic       write;
  } dphase_t;
endpackage

// File: rtl/ahb_fifo_core.sv
// Word-wide synchronous FIFO with flush; storage is not reset, only pointers and count.
module ahb_fifo_core #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/ahb_lite_fifo_slave.sv
// AHB-Lite slave fronting a FIFO mailbox: DATA/STATUS/CTRL registers, wait states, ERROR responses.
module ahb_lite_fifo_slave
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [29:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        Interrupt
);
  localparam int         CW      = $clog2(DEPTH) + 1;
  localparam logic [1:0] WS_INIT = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  bus_state_t    state;
  dphase_t       ph;
  logic [1:0]    wait_cnt;
  logic          hready_r, hresp_r, irq_en, irq_r;
  logic [CW-1:0] count, count_after;
  logic          full, empty;
  logic [31:0]   fifo_rdata, status, ctrl;
  logic          done, push, pop, ctrl_wr, flush, accept, legal;
  logic [1:0]    off;
  logic          unused;

  assign unused = ^{HADDR[29:2], HTRANS[0]};

  assign done    = (state == ST_WAIT) && hready_r;
  assign push    = done && ph.write && (ph.off == OFF_DATA);
  assign pop     = done && !ph.write && (ph.off == OFF_DATA);
  assign ctrl_wr = done && ph.write && (ph.off == OFF_CTRL);
  assign flush   = ctrl_wr && HWDATA[CTRL_FLUSH];

  assign off    = HADDR[1:0];
  assign accept = HSEL && HTRANS[1] && hready_r;

  // Legality sees the FIFO level after whatever completes on this same edge.
  always_comb begin
    count_after = count;
    if (flush)     count_after = '0;
    else if (push) count_after = count + CW'(1);
    else if (pop)  count_after = count - CW'(1);
  end

  assign legal = (HSIZE == HSIZE_WORD) && (off != OFF_RSVD)
              && !(HWRITE && off == OFF_STATUS)
              && !(off == OFF_DATA && HWRITE && count_after == CW'(DEPTH))
              && !(off == OFF_DATA && !HWRITE && count_after == '0);

  always_comb begin
    status = '0;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL]  = full;
    status[STAT_CNT_LSB +: 8] = 8'(count);
    ctrl = '0;
    ctrl[CTRL_IRQ_EN] = irq_en;
  end

  always_comb begin
    HRDATA = '0;
    if (done && !ph.write) begin
      case (ph.off)
        OFF_DATA:   HRDATA = fifo_rdata;
        OFF_STATUS: HRDATA = status;
        OFF_CTRL:   HRDATA = ctrl;
        default:    HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      ph       <= '0;
      wait_cnt <= '0;
      hready_r <= 1'b1;
      hresp_r  <= HRESP_OKAY;
      irq_en   <= 1'b0;
      irq_r    <= 1'b0;
    end else begin
      irq_r <= irq_en & ~empty;
      if (ctrl_wr) irq_en <= HWDATA[CTRL_IRQ_EN];
      if (accept) begin
        ph.off   <= off;
        ph.write <= HWRITE;
        if (!legal) begin
          state    <= ST_ERR1;
          hready_r <= 1'b0;
          hresp_r  <= HRESP_ERROR;
        end else begin
          state    <= ST_WAIT;
          hready_r <= (WAIT_STATES == 0);
          hresp_r  <= HRESP_OKAY;
          wait_cnt <= WS_INIT;
        end
      end else begin
        case (state)
          ST_WAIT: begin
            if (!hready_r) begin
              if (wait_cnt == 2'd0) hready_r <= 1'b1;
              else                  wait_cnt <= wait_cnt - 2'd1;
            end else begin
              state   <= ST_IDLE;
              hresp_r <= HRESP_OKAY;
            end
          end
          ST_ERR1: begin
            state    <= ST_ERR2;
            hready_r <= 1'b1;
          end
          default: begin
            state    <= ST_IDLE;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
          end
        endcase
      end
    end
  end

  assign HREADY    = hready_r;
  assign HRESP     = hresp_r;
  assign Interrupt = irq_r;

  ahb_fifo_core #(.DEPTH(DEPTH)) u_fifo (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (HWDATA),
    .rdata (fifo_rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_ahb_lite_fifo_slave.sv
// Bench: directed vector table, hand-driven pipelined/reset corners, then random ops vs a queue model.
module tb_ahb_lite_fifo_slave;
  localparam int DEPTH = 8;
  localparam int WS    = 1;
  localparam logic RD = 1'b0, WR = 1'b1, OK = 1'b0, ER = 1'b1;
  localparam logic [2:0] W = 3'b010, B = 3'b000;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [29:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP, Interrupt;

  int vectors = 0;
  int miscompares = 0;

  ahb_lite_fifo_slave #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP), .Interrupt(Interrupt)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        wr;
    logic [1:0]  off;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[16];

  // Behavioural reference: a queue of words plus the irq enable bit.
  logic [31:0] mq[$];
  logic        m_irq_en;

  function automatic vec_t mk(input logic wr, input logic [1:0] off, input logic [2:0] sz,
                              input logic [31:0] wd, input logic err, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.off = off; v.sz = sz; v.wd = wd; v.err = err; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One non-pipelined transfer; returns read data, {first-cycle HRESP, last-cycle HRESP}, length.
  task automatic xfer(input logic wr, input logic [1:0] off, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] resp,
                      output int lat);
    logic first;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = {28'h0, off}; HWRITE = wr; HSIZE = sz; HWDATA = '0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
    lat = 1;
    first = HRESP;
    while (!HREADY && lat < 8) begin
      @(posedge HCLK); #1;
      lat++;
    end
    rd = HRDATA;
    resp = {first, HRESP};
    @(posedge HCLK); #1;
  endtask

  task automatic do_op(input string nm, input logic wr, input logic [1:0] off, input logic [2:0] sz,
                       input logic [31:0] wd, input logic err, input logic [31:0] exp_rd);
    logic [31:0] rd;
    logic [1:0]  resp;
    int          lat;
    xfer(wr, off, sz, wd, rd, resp, lat);
    chk({nm, "_resp"}, 32'(resp), err ? 32'h3 : 32'h0);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_len"}, 32'(lat), err ? 32'd2 : 32'(WS + 1));
  endtask

  task automatic model_op(input logic wr, input logic [1:0] off, input logic [2:0] sz,
                          input logic [31:0] wd, output logic e, output logic [31:0] r);
    int n;
    n = mq.size();
    e = 1'b0;
    r = '0;
    if (sz != 3'b010 || off == 2'd3) e = 1'b1;
    else if (off == 2'd0) begin
      if (wr) begin
        if (n == DEPTH) e = 1'b1; else mq.push_back(wd);
      end else begin
        if (n == 0) e = 1'b1; else r = mq.pop_front();
      end
    end else if (off == 2'd1) begin
      if (wr) e = 1'b1;
      else begin
        r = 32'(n) << 8;
        r[1] = (n == DEPTH);
        r[0] = (n == 0);
      end
    end else begin
      if (wr) begin
        m_irq_en = wd[0];
        if (wd[1]) mq.delete();
      end else r = {31'b0, m_irq_en};
    end
  endtask

  task automatic reset_all();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    mq.delete();
    m_irq_en = 1'b0;
  endtask

  initial begin
    logic        e;
    logic [31:0] r;
    logic [1:0]  off;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    int          sel;

    tbl[0]  = mk(RD, 2'd1, W, 32'h0,         OK, 32'h0000_0001);
    tbl[1]  = mk(WR, 2'd0, W, 32'hA5A5_0001, OK, 32'h0);
    tbl[2]  = mk(RD, 2'd1, W, 32'h0,         OK, 32'h0000_0100);
    tbl[3]  = mk(RD, 2'd0, W, 32'h0,         OK, 32'hA5A5_0001);
    tbl[4]  = mk(RD, 2'd1, W, 32'h0,         OK, 32'h0000_0001);
    tbl[5]  = mk(RD, 2'd0, W, 32'h0,         ER, 32'h0);
    tbl[6]  = mk(RD, 2'd1, B, 32'h0,         ER, 32'h0);
    tbl[7]  = mk(WR, 2'd3, W, 32'h1234_5678, ER, 32'h0);
    tbl[8]  = mk(WR, 2'd1, W, 32'hFFFF_FFFF, ER, 32'h0);
    tbl[9]  = mk(RD, 2'd1, W, 32'h0,         OK, 32'h0000_0001);
    tbl[10] = mk(WR, 2'd2, W, 32'h0000_0001, OK, 32'h0);
    tbl[11] = mk(RD, 2'd2, W, 32'h0,         OK, 32'h0000_0001);
    tbl[12] = mk(WR, 2'd0, B, 32'h5555_AAAA, ER, 32'h0);
    tbl[13] = mk(RD, 2'd1, W, 32'h0,         OK, 32'h0000_0001);
    tbl[14] = mk(WR, 2'd2, W, 32'h0000_0000, OK, 32'h0);
    tbl[15] = mk(RD, 2'd3, W, 32'h0,         ER, 32'h0);

    HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = W; HTRANS = 2'b00; HWDATA = '0;
    HRESETn = 1'b0;
    m_irq_en = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hready", 32'(HREADY), 32'h1);
    chk("rst_hresp", 32'(HRESP), 32'h0);
    chk("rst_irq", 32'(Interrupt), 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("idle_hready", 32'(HREADY), 32'h1);

    for (int i = 0; i < 16; i++)
      do_op($sformatf("tbl%0d", i), tbl[i].wr, tbl[i].off, tbl[i].sz, tbl[i].wd, tbl[i].err, tbl[i].rd);

    // Pipelined push then pop from an empty FIFO: the pop is legal due to the same-edge push.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = '0; HWRITE = 1'b1; HSIZE = W;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1234_5678;
    chk("b2b_push_wait", {30'h0, HREADY, HRESP}, 32'h0);
    @(posedge HCLK); #1;
    chk("b2b_push_done", {30'h0, HREADY, HRESP}, 32'h2);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = '0; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    chk("b2b_pop_wait", {30'h0, HREADY, HRESP}, 32'h0);
    @(posedge HCLK); #1;
    chk("b2b_pop_done", {30'h0, HREADY, HRESP}, 32'h2);
    chk("b2b_pop_data", HRDATA, 32'h1234_5678);
    @(posedge HCLK); #1;
    do_op("b2b_status", RD, 2'd1, W, 32'h0, OK, 32'h1);

    // Interrupt timing and flush.
    do_op("irq_en", WR, 2'd2, W, 32'h1, OK, 32'h0);
    do_op("irq_push", WR, 2'd0, W, 32'hBEEF_0001, OK, 32'h0);
    chk("irq_not_yet", 32'(Interrupt), 32'h0);
    @(posedge HCLK); #1;
    chk("irq_rise", 32'(Interrupt), 32'h1);
    do_op("flush", WR, 2'd2, W, 32'h3, OK, 32'h0);
    do_op("flush_status", RD, 2'd1, W, 32'h0, OK, 32'h1);
    chk("irq_fall", 32'(Interrupt), 32'h0);
    do_op("flush_ctrl", RD, 2'd2, W, 32'h0, OK, 32'h1);
    do_op("irq_dis", WR, 2'd2, W, 32'h0, OK, 32'h0);

    // Fill to full, overflow, and drain the head.
    for (int i = 0; i < DEPTH; i++)
      do_op($sformatf("fill%0d", i), WR, 2'd0, W, 32'hC0DE_0000 + 32'(i), OK, 32'h0);
    do_op("full_status", RD, 2'd1, W, 32'h0, OK, 32'h0000_0802);
    do_op("overflow", WR, 2'd0, W, 32'hBAD0_BAD0, ER, 32'h0);
    do_op("full_status2", RD, 2'd1, W, 32'h0, OK, 32'h0000_0802);
    do_op("pop_head", RD, 2'd0, W, 32'h0, OK, 32'hC0DE_0000);
    do_op("after_pop", RD, 2'd1, W, 32'h0, OK, 32'h0000_0700);

    // Reset during the wait state of a push.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = '0; HWRITE = 1'b1; HSIZE = W;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hDEAD_BEEF;
    chk("rstmid_wait", 32'(HREADY), 32'h0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk("rstmid_hready", 32'(HREADY), 32'h1);
    chk("rstmid_hresp", 32'(HRESP), 32'h0);
    HRESETn = 1'b1;
    do_op("rstmid_status", RD, 2'd1, W, 32'h0, OK, 32'h1);
    do_op("rstmid_pop", RD, 2'd0, W, 32'h0, ER, 32'h0);

    // Random traffic against the queue model.
    reset_all();
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6) begin
        off = 2'd0;
        wr  = ($urandom_range(0, 99) < ((i < 200) ? 65 : 35));
      end else begin
        off = (sel == 6) ? 2'd1 : (sel == 7 || sel == 8) ? 2'd2 : 2'd3;
        wr  = 1'($urandom_range(0, 1));
      end
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : W;
      wd = $urandom;
      if (off == 2'd2 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
      model_op(wr, off, sz, wd, e, r);
      do_op($sformatf("rnd%0d", i), wr, off, sz, wd, e, r);
      @(posedge HCLK); #1;
      chk($sformatf("rnd%0d_irq", i), 32'(Interrupt), 32'(m_irq_en && mq.size() != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
